ysyx_23060208_sram_rd_arbiter: RTL and testbench
================================================

// Module: ysyx_23060208_sram_rd_arbiter
// PURPOSE
//  Shares the single SRAM AXI4-lite read port (AR + R channels) between IFU (fetch) and LSU (load).
//  Sits between the two masters and the SRAM slave; grants one whole read transaction (AR then R) at a time.
//  LSU write channels (AW/W/B) bypass this block and go straight to the SRAM.
// PARAMETERS
//  DATA_WIDTH  32  width of address and read-data buses
// PORTS
//  clk          in   1           core clock
//  rst          in   1           asynchronous reset, active-high
//  ifu_araddr   in   DATA_WIDTH  IFU read address
//  ifu_arvalid  in   1           IFU read request
//  ifu_arready  out  1           AR accepted for IFU
//  ifu_rdata    out  DATA_WIDTH  read data to IFU (0 when not owner)
//  ifu_rresp    out  2           read response to IFU (0 when not owner)
//  ifu_rvalid   out  1           read data valid to IFU
//  ifu_rready   in   1           IFU can accept R
//  lsu_araddr   in   DATA_WIDTH  LSU read address
//  lsu_arvalid  in   1           LSU read request
//  lsu_arready  out  1           AR accepted for LSU
//  lsu_rdata    out  DATA_WIDTH  read data to LSU (0 when not owner)
//  lsu_rresp    out  2           read response to LSU (0 when not owner)
//  lsu_rvalid   out  1           read data valid to LSU
//  lsu_rready   in   1           LSU can accept R
//  sram_araddr  out  DATA_WIDTH  address to SRAM
//  sram_arvalid out  1           request to SRAM
//  sram_arready in   1           SRAM accepts AR
//  sram_rdata   in   DATA_WIDTH  SRAM read data
//  sram_rresp   in   2           SRAM read response
//  sram_rvalid  in   1           SRAM read data valid
//  sram_rready  out  1           R accepted by owner
// BEHAVIOUR
//  - FSM states: IDLE, OWN_IFU, OWN_LSU, plus flag ar_done (AR handshake already made this grant).
//  - Reset (async, immediate): state=IDLE, ar_done=0; every valid/ready output 0, araddr/rdata/rresp outputs 0.
//  - IDLE: sample arvalid of both; grant registered -> arbitration latency 1 cycle; no sram_arvalid in IDLE.
//  - Owner state: sram_araddr=owner araddr; sram_arvalid=owner arvalid & !ar_done; owner arready=sram_arready & !ar_done.
//  - AR handshake (sram_arvalid & sram_arready): ar_done<=1; one AR per grant, never a second.
//  - R path: owner rvalid=sram_rvalid & ar_done; sram_rready=owner rready & ar_done; rdata/rresp passed to owner only.
//  - R handshake (sram_rvalid & sram_rready): state<=IDLE, ar_done<=0 same edge; min grant-to-grant gap 1 IDLE cycle.
//  - Non-owner: arready=0, rvalid=0; its arvalid held pending, never dropped or lost.
//  - Simultaneous requests in IDLE: resolved by arbitration policy (see CONFIGURATION).
//  - Owner deasserting arvalid before AR handshake is an AXI violation; grant still held, no timeout.
//  - sram_rvalid with ar_done=0 or in IDLE: ignored, not forwarded (slave bug, assert in sim).
//  - rresp passed through unmodified; non-OKAY still ends the transaction normally.
// CONFIGURATION
//  YSYX_23060208_ARB_RR_EN defined: round-robin; last_owner reg (reset=IFU) -> on tie grant the other master.
//  Undefined: fixed priority, LSU wins every tie (loads block fetch; IFU starves while LSU requests back-to-back).
// TESTING
//  IFU arvalid only, araddr=0x80000000, SRAM arready=1, rvalid next cycle rdata=0x00000413 -> ifu_rvalid & ifu_rdata=0x00000413; lsu_rvalid=0.
//  IFU+LSU arvalid same cycle, fixed priority -> LSU granted first, IFU AR sent only after LSU R handshake + 1 IDLE cycle.
//  Same tie with RR_EN, last_owner=LSU -> IFU granted first; repeated ties alternate IFU,LSU,IFU.
//  Owner rready=0 for 3 cycles while sram_rvalid=1 -> sram_rready=0, grant held, data delivered on 4th cycle.
//  sram_arready=0 for 5 cycles -> owner arready=0 and sram_araddr stable for all 5 cycles; exactly one AR accepted.
//  rst asserted mid-R (after AR, before R) -> all valids drop same cycle, state=IDLE; new request re-arbitrated after release.

Source files
------------

// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
// ============================================================================
// Module      : ysyx_23060208_sram_rd_arbiter
// Description : Shares the single SRAM AXI4-lite read port (AR + R) between
//               the IFU (fetch) and the LSU (load). One whole read
//               transaction (AR then R) is granted at a time. LSU write
//               channels do not pass through this block.
// Config      : YSYX_23060208_ARB_RR_EN -- when defined, ties are resolved
//               round-robin. When undefined, the LSU wins every tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060208_sram_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // IFU read master
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // LSU read master
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // SRAM read slave
  output logic [DATA_WIDTH-1:0] sram_araddr,
  output logic                  sram_arvalid,
  input  logic                  sram_arready,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [1:0]            sram_rresp,
  input  logic                  sram_rvalid,
  output logic                  sram_rready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_IFU = 2'd1,
    OWN_LSU = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Set once the AR handshake of the current grant has happened, so that a
  // grant issues exactly one AR and only then opens the R path.
  logic ar_done;

  logic ar_hs;
  logic r_hs;

`ifdef YSYX_23060208_ARB_RR_EN
  // 1 when the most recent grant went to the LSU; reset value means IFU.
  logic last_owner_lsu;
`endif

  assign ar_hs = sram_arvalid & sram_arready;
  assign r_hs  = sram_rvalid & sram_rready;

  // Grant state register: the arbitration decision is registered, so a
  // request seen in IDLE is served starting on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // AR-done flag: set on the AR handshake, cleared on the R handshake that
  // also returns the FSM to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_done <= 1'b0;
    end else if (state != IDLE && r_hs) begin
      ar_done <= 1'b0;
    end else if (state != IDLE && ar_hs) begin
      ar_done <= 1'b1;
    end
  end

`ifdef YSYX_23060208_ARB_RR_EN
  // Remember who was granted last so the next tie goes the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_lsu <= 1'b0;
    end else if (state == IDLE && state_next == OWN_LSU) begin
      last_owner_lsu <= 1'b1;
    end else if (state == IDLE && state_next == OWN_IFU) begin
      last_owner_lsu <= 1'b0;
    end
  end
`endif

  // Next-state logic: arbitrate in IDLE, release the grant on R handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef YSYX_23060208_ARB_RR_EN
        if (ifu_arvalid && lsu_arvalid) begin
          state_next = last_owner_lsu ? OWN_IFU : OWN_LSU;
        end else if (lsu_arvalid) begin
          state_next = OWN_LSU;
        end else if (ifu_arvalid) begin
          state_next = OWN_IFU;
        end
`else
        // Loads take precedence over fetch on every tie.
        if (lsu_arvalid) begin
          state_next = OWN_LSU;
        end else if (ifu_arvalid) begin
          state_next = OWN_IFU;
        end
`endif
      end
      OWN_IFU, OWN_LSU: begin
        // The grant is held (even if the owner drops arvalid) until the
        // single read transaction finishes.
        if (r_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output routing: connect only the owner to the SRAM port; the
  // non-owner sees zeros and its request stays pending.
  always_comb begin
    sram_araddr  = '0;
    sram_arvalid = 1'b0;
    sram_rready  = 1'b0;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = '0;
    ifu_rresp    = 2'b00;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    lsu_rresp    = 2'b00;
    case (state)
      OWN_IFU: begin
        sram_araddr  = ifu_araddr;
        sram_arvalid = ifu_arvalid & ~ar_done;
        ifu_arready  = sram_arready & ~ar_done;
        ifu_rvalid   = sram_rvalid & ar_done;
        sram_rready  = ifu_rready & ar_done;
        ifu_rdata    = sram_rdata;
        ifu_rresp    = sram_rresp;
      end
      OWN_LSU: begin
        sram_araddr  = lsu_araddr;
        sram_arvalid = lsu_arvalid & ~ar_done;
        lsu_arready  = sram_arready & ~ar_done;
        lsu_rvalid   = sram_rvalid & ar_done;
        sram_rready  = lsu_rready & ar_done;
        lsu_rdata    = sram_rdata;
        lsu_rresp    = sram_rresp;
      end
      default: begin
      end
    endcase
  end

`ifndef SYNTHESIS
  // Read data arriving before an AR was issued for this grant is a slave
  // bug; it is dropped by the routing above and flagged here.
  sram_rvalid_without_ar: assert property (
    @(posedge clk) disable iff (rst) sram_rvalid |-> ar_done
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
// ============================================================================
// Module      : tb_ysyx_23060208_sram_rd_arbiter
// Description : Directed self-checking bench for the SRAM read arbiter.
//               Expected owner order follows YSYX_23060208_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060208_sram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] sram_araddr;
  logic        sram_arvalid;
  logic        sram_arready;
  logic [31:0] sram_rdata;
  logic [1:0]  sram_rresp;
  logic        sram_rvalid;
  logic        sram_rready;

  int checks = 0;
  int errors = 0;

  ysyx_23060208_sram_rd_arbiter #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_araddr   (ifu_araddr),
    .ifu_arvalid  (ifu_arvalid),
    .ifu_arready  (ifu_arready),
    .ifu_rdata    (ifu_rdata),
    .ifu_rresp    (ifu_rresp),
    .ifu_rvalid   (ifu_rvalid),
    .ifu_rready   (ifu_rready),
    .lsu_araddr   (lsu_araddr),
    .lsu_arvalid  (lsu_arvalid),
    .lsu_arready  (lsu_arready),
    .lsu_rdata    (lsu_rdata),
    .lsu_rresp    (lsu_rresp),
    .lsu_rvalid   (lsu_rvalid),
    .lsu_rready   (lsu_rready),
    .sram_araddr  (sram_araddr),
    .sram_arvalid (sram_arvalid),
    .sram_arready (sram_arready),
    .sram_rdata   (sram_rdata),
    .sram_rresp   (sram_rresp),
    .sram_rvalid  (sram_rvalid),
    .sram_rready  (sram_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete granted read: called in IDLE with the owner's request up.
  // The owner drops arvalid after its AR handshake; the other stays as is.
  task automatic txn(input bit lsu, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] resp, input string tag);
    chk({tag, ".idle_arvalid"}, {31'd0, sram_arvalid}, 32'd0);
    tick();
    chk({tag, ".araddr"}, sram_araddr, addr);
    chk({tag, ".arvalid"}, {31'd0, sram_arvalid}, 32'd1);
    chk({tag, ".own_arready"}, {31'd0, lsu ? lsu_arready : ifu_arready}, 32'd1);
    chk({tag, ".oth_arready"}, {31'd0, lsu ? ifu_arready : lsu_arready}, 32'd0);
    tick();
    if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = data;
    sram_rresp  = resp;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    #1;
    chk({tag, ".no_2nd_ar"}, {31'd0, sram_arvalid}, 32'd0);
    chk({tag, ".own_rvalid"}, {31'd0, lsu ? lsu_rvalid : ifu_rvalid}, 32'd1);
    chk({tag, ".own_rdata"}, lsu ? lsu_rdata : ifu_rdata, data);
    chk({tag, ".own_rresp"}, {30'd0, lsu ? lsu_rresp : ifu_rresp}, {30'd0, resp});
    chk({tag, ".oth_rvalid"}, {31'd0, lsu ? ifu_rvalid : lsu_rvalid}, 32'd0);
    chk({tag, ".oth_rdata"}, lsu ? ifu_rdata : lsu_rdata, 32'd0);
    chk({tag, ".sram_rready"}, {31'd0, sram_rready}, 32'd1);
    tick();
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    sram_rresp  = 2'b00;
    #1;
    chk({tag, ".end_rvalid"}, {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
  endtask

  // Watchdog: the directed sequence is short, so any overrun is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b0;
    sram_arready = 1'b0; sram_rdata = '0; sram_rresp = 2'b00; sram_rvalid = 1'b0;
    tick();
    tick();

    // Reset state: everything quiet.
    chk("rst.sram_arvalid", {31'd0, sram_arvalid}, 32'd0);
    chk("rst.sram_araddr", sram_araddr, 32'd0);
    chk("rst.sram_rready", {31'd0, sram_rready}, 32'd0);
    chk("rst.arready", {30'd0, ifu_arready, lsu_arready}, 32'd0);
    chk("rst.rvalid", {30'd0, ifu_rvalid, lsu_rvalid}, 32'd0);
    chk("rst.rdata", ifu_rdata | lsu_rdata, 32'd0);
    rst = 1'b0;
    sram_arready = 1'b1;

    // IFU alone: fetch 0x80000000 returns 0x00000413.
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h8000_0000;
    #1;
    chk("t1.idle_arready", {31'd0, ifu_arready}, 32'd0);
    txn(1'b0, 32'h8000_0000, 32'h0000_0413, 2'b00, "t1");

    // Tie after an IFU grant: LSU first in both modes; SLVERR passes through.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_1000;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_2000;
    txn(1'b1, 32'h0000_2000, 32'hAAAA_5555, 2'b10, "t2lsu");
    // Pending IFU goes out only after one IDLE cycle; owner stalls R for 3.
    chk("t2.idle_arvalid", {31'd0, sram_arvalid}, 32'd0);
    tick();
    chk("t2.ifu_araddr", sram_araddr, 32'h0000_1000);
    chk("t2.ifu_arready", {31'd0, ifu_arready}, 32'd1);
    tick();
    ifu_arvalid = 1'b0;
    ifu_rready  = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h1234_5678;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t2.hold_sram_rready", {31'd0, sram_rready}, 32'd0);
      chk("t2.hold_rvalid", {31'd0, ifu_rvalid}, 32'd1);
      tick();
    end
    ifu_rready = 1'b1;
    #1;
    chk("t2.rel_sram_rready", {31'd0, sram_rready}, 32'd1);
    chk("t2.rel_rdata", ifu_rdata, 32'h1234_5678);
    tick();
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    #1;
    chk("t2.end_rvalid", {31'd0, ifu_rvalid}, 32'd0);

    // LSU alone with SRAM AR stalled for 5 cycles.
    sram_arready = 1'b0;
    lsu_arvalid  = 1'b1;
    lsu_araddr   = 32'h0000_3000;
    #1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3.stall_arready", {31'd0, lsu_arready}, 32'd0);
      chk("t3.stall_araddr", sram_araddr, 32'h0000_3000);
      chk("t3.stall_arvalid", {31'd0, sram_arvalid}, 32'd1);
      tick();
    end
    sram_arready = 1'b1;
    #1;
    chk("t3.arready", {31'd0, lsu_arready}, 32'd1);
    tick();
    chk("t3.one_ar_arvalid", {31'd0, sram_arvalid}, 32'd0);
    chk("t3.one_ar_arready", {31'd0, lsu_arready}, 32'd0);
    lsu_arvalid = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'hCAFE_0003;
    #1;
    chk("t3.rdata", lsu_rdata, 32'hCAFE_0003);
    tick();
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    #1;

    // Repeated ties with the LSU as last owner.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h0000_0100;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0200;
`ifdef YSYX_23060208_ARB_RR_EN
    txn(1'b0, 32'h0000_0100, 32'h0000_0A01, 2'b00, "t4a");
    ifu_arvalid = 1'b1;
    txn(1'b1, 32'h0000_0200, 32'h0000_0A02, 2'b00, "t4b");
    lsu_arvalid = 1'b1;
    txn(1'b0, 32'h0000_0100, 32'h0000_0A03, 2'b00, "t4c");
    txn(1'b1, 32'h0000_0200, 32'h0000_0A04, 2'b00, "t4d");
`else
    txn(1'b1, 32'h0000_0200, 32'h0000_0A01, 2'b00, "t4a");
    lsu_arvalid = 1'b1;
    txn(1'b1, 32'h0000_0200, 32'h0000_0A02, 2'b00, "t4b");
    lsu_arvalid = 1'b1;
    txn(1'b1, 32'h0000_0200, 32'h0000_0A03, 2'b00, "t4c");
    txn(1'b0, 32'h0000_0100, 32'h0000_0A04, 2'b00, "t4d");
`endif

    // Reset in the middle of the R phase.
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h0000_0500;
    tick();
    tick();
    ifu_arvalid = 1'b0;
    ifu_rready  = 1'b1;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h0000_0555;
    #1;
    chk("t5.pre_rvalid", {31'd0, ifu_rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5.rst_rvalid", {31'd0, ifu_rvalid}, 32'd0);
    chk("t5.rst_sram_rready", {31'd0, sram_rready}, 32'd0);
    chk("t5.rst_rdata", ifu_rdata, 32'd0);
    sram_rvalid = 1'b0;
    sram_rdata  = '0;
    tick();
    rst = 1'b0;
    lsu_arvalid = 1'b1;
    lsu_araddr  = 32'h0000_0600;
    #1;
    txn(1'b1, 32'h0000_0600, 32'h0000_0666, 2'b00, "t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
